// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer for a 128x24 synchronous memory: fetch (read-only)
// and data (read/write) share one port. Define MEM_ARB_RR_EN for round-robin arbitration.
`timescale 1ns/1ps

module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 24,
  parameter int DEPTH  = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_MAR,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_EN,
  output logic              mem_CS,
  input  logic [DATA_W-1:0] mem_data_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   mar_q, mar_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                en_q, en_d;
  logic                cs_q, cs_d;
  logic                is_data_q, is_data_d;
  logic                addr_err_q, addr_err_d;
  logic                f_ack_q, f_ack_d;
  logic                d_ack_q, d_ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                grant_data;
  logic [ADDR_W-1:0]   req_addr;
  logic                in_range;
`ifdef MEM_ARB_RR_EN
  logic                last_data_q, last_data_d;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    mar_d      = mar_q;
    wdata_d    = wdata_q;
    en_d       = en_q;
    cs_d       = cs_q;
    is_data_d  = is_data_q;
    addr_err_d = addr_err_q;
    rdata_d    = rdata_q;
    f_ack_d    = 1'b0;
    d_ack_d    = 1'b0;
    err_d      = 1'b0;
    grant_data = 1'b0;
    req_addr   = '0;
    in_range   = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_data_d = last_data_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (f_req || d_req) begin
`ifdef MEM_ARB_RR_EN
          // Under contention the requester not served last wins.
          grant_data  = d_req && (!f_req || !last_data_q);
          last_data_d = grant_data;
`else
          grant_data  = d_req;
`endif
          req_addr   = grant_data ? d_addr : f_addr;
          in_range   = (32'(req_addr) < 32'(DEPTH));
          mar_d      = req_addr;
          wdata_d    = grant_data ? d_wdata : '0;
          cs_d       = grant_data && d_we;
          en_d       = in_range;
          addr_err_d = !in_range;
          is_data_d  = grant_data;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        en_d    = 1'b0;
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        f_ack_d = !is_data_q;
        d_ack_d = is_data_q;
        if (addr_err_q) begin
          rdata_d = '0;
          err_d   = 1'b1;
        end else if (!cs_q) begin
          rdata_d = mem_data_out;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      mar_q      <= '0;
      wdata_q    <= '0;
      en_q       <= 1'b0;
      cs_q       <= 1'b0;
      is_data_q  <= 1'b0;
      addr_err_q <= 1'b0;
      f_ack_q    <= 1'b0;
      d_ack_q    <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_data_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      mar_q      <= mar_d;
      wdata_q    <= wdata_d;
      en_q       <= en_d;
      cs_q       <= cs_d;
      is_data_q  <= is_data_d;
      addr_err_q <= addr_err_d;
      f_ack_q    <= f_ack_d;
      d_ack_q    <= d_ack_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
`ifdef MEM_ARB_RR_EN
      last_data_q <= last_data_d;
`endif
    end
  end

  assign mem_MAR     = mar_q;
  assign mem_data_in = wdata_q;
  assign mem_EN      = en_q;
  assign mem_CS      = cs_q;
  assign f_ack       = f_ack_q;
  assign d_ack       = d_ack_q;
  assign rdata       = rdata_q;
  assign err         = err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a behavioural memory device, a shadow-memory
// reference model feeding an expectation queue, and an ack monitor that pops and compares.
`timescale 1ns/1ps

module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req, d_req, d_we;
  logic [7:0]  f_addr, d_addr;
  logic [23:0] d_wdata;
  logic        f_ack, d_ack, err, busy;
  logic [23:0] rdata;
  logic [7:0]  mem_MAR;
  logic [23:0] mem_data_in, mem_data_out;
  logic        mem_EN, mem_CS;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .rdata(rdata), .err(err), .busy(busy),
    .mem_MAR(mem_MAR), .mem_data_in(mem_data_in), .mem_EN(mem_EN), .mem_CS(mem_CS),
    .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // Synchronous 128x24 memory device
  logic [23:0] mem_array [128];
  always @(posedge clk) begin
    if (mem_EN) begin
      if (mem_CS) mem_array[mem_MAR[6:0]] <= mem_data_in;
      else        mem_data_out <= mem_array[mem_MAR[6:0]];
    end
  end

  // Reference model state
  typedef struct {
    bit          is_data;
    logic [23:0] rdata;
    bit          err;
  } exp_t;

  exp_t        exp_q[$];
  logic [23:0] ref_mem [128];
  logic [23:0] m_rdata;
  bit          m_last_data;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: no ack within cycle budget at %0t", name, $time);
  endtask

  function automatic bit pick_data(bit fe, bit de);
    if (!fe) return 1'b1;
    if (!de) return 1'b0;
`ifdef MEM_ARB_RR_EN
    return !m_last_data;
`else
    return 1'b1;
`endif
  endfunction

  function automatic void model_access(bit is_data, bit we, logic [7:0] a, logic [23:0] wd);
    exp_t e;
    e.is_data = is_data;
    e.err     = 1'b0;
    if (a >= 8'd128) begin
      m_rdata = '0;
      e.err   = 1'b1;
    end else if (we) begin
      ref_mem[a[6:0]] = wd;
    end else begin
      m_rdata = ref_mem[a[6:0]];
    end
    e.rdata = m_rdata;
    exp_q.push_back(e);
    m_last_data = is_data;
  endfunction

  function automatic void model_reset();
    m_rdata     = '0;
    m_last_data = 1'b0;
  endfunction

  // Monitor: every ack pops one expectation
  always @(negedge clk) begin
    if (!reset && (f_ack || d_ack)) begin
      exp_t e;
      check("ack_exclusive", {31'd0, f_ack && d_ack}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: f_ack=%0b d_ack=%0b with no pending request at %0t",
                 f_ack, d_ack, $time);
      end else begin
        e = exp_q.pop_front();
        check("ack_port_is_data", {31'd0, d_ack}, {31'd0, e.is_data});
        check("rdata", {8'd0, rdata}, {8'd0, e.rdata});
        check("err", {31'd0, err}, {31'd0, e.err});
      end
    end
  end

  // One transaction (single or simultaneous pair); each requester holds until acked
  task automatic run_txn(input bit fe, input logic [7:0] fa, input bit de, input bit dwe,
                         input logic [7:0] da, input logic [23:0] dwd);
    int n, cyc, got, last_ack, en_cnt;
    logic [7:0] en_mar;
    bit en_cs, first_data;
    n = int'(fe) + int'(de);
    first_data = pick_data(fe, de);
    if (first_data) begin
      model_access(1'b1, dwe, da, dwd);
      if (fe) model_access(1'b0, 1'b0, fa, '0);
    end else begin
      model_access(1'b0, 1'b0, fa, '0);
      if (de) model_access(1'b1, dwe, da, dwd);
    end
    @(negedge clk);
    f_req = fe; f_addr = fa;
    d_req = de; d_we = dwe; d_addr = da; d_wdata = dwd;
    cyc = 0; got = 0; last_ack = 0; en_cnt = 0; en_mar = '0; en_cs = 1'b0;
    while (got < n && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (mem_EN) begin
        en_cnt++;
        en_mar = mem_MAR;
        en_cs  = mem_CS;
      end
      if (f_ack || d_ack) begin
        got++;
        if (got == 1) check("ack_latency", cyc, 3);
        else          check("ack_spacing", cyc - last_ack, 4);
        last_ack = cyc;
        if (d_ack) d_req = 1'b0;
        if (f_ack) f_req = 1'b0;
      end
    end
    if (got < n) begin
      timeout_fail("run_txn");
      f_req = 1'b0;
      d_req = 1'b0;
    end
    if (n == 1) begin
      logic [7:0] a;
      bit we;
      a  = de ? da : fa;
      we = de && dwe;
      check("en_cycles", en_cnt, (a < 8'd128) ? 1 : 0);
      if (a < 8'd128) begin
        check("mar_on_en", {24'd0, en_mar}, {24'd0, a});
        check("cs_on_en", {31'd0, en_cs}, {31'd0, we});
      end
    end
  endtask

  // Requests held continuously for cnt grants; the acked requester moves to a new address
  task automatic held_seq(input bit fe, input bit de, input int cnt);
    logic [7:0] fa [10];
    logic [7:0] da [10];
    int fi, di, cyc, got, last_ack;
    for (int i = 0; i < 10; i++) begin
      fa[i] = 8'($urandom_range(0, 127));
      da[i] = 8'($urandom_range(0, 127));
    end
    fi = 0; di = 0;
    for (int k = 0; k < cnt; k++) begin
      if (pick_data(fe, de)) begin
        model_access(1'b1, 1'b0, da[di], '0);
        di++;
      end else begin
        model_access(1'b0, 1'b0, fa[fi], '0);
        fi++;
      end
    end
    @(negedge clk);
    fi = 0; di = 0;
    f_req = fe; f_addr = fa[0];
    d_req = de; d_we = 1'b0; d_addr = da[0]; d_wdata = '0;
    cyc = 0; got = 0; last_ack = 0;
    while (got < cnt && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (f_ack || d_ack) begin
        got++;
        if (got == 1) check("held_latency", cyc, 3);
        else          check("held_spacing", cyc - last_ack, 4);
        last_ack = cyc;
        if (d_ack) begin di++; d_addr = da[di]; end
        if (f_ack) begin fi++; f_addr = fa[fi]; end
      end
    end
    if (got < cnt) timeout_fail("held_seq");
    f_req = 1'b0;
    d_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    f_req = 1'b0; f_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < 128; i++) begin
      mem_array[i] = 24'($urandom);
      ref_mem[i]   = mem_array[i];
    end
    mem_array[20] = 24'h3128A;
    ref_mem[20]   = 24'h3128A;
    model_reset();

    repeat (3) @(negedge clk);
    check("rst_mem_EN", {31'd0, mem_EN}, 32'd0);
    check("rst_mem_CS", {31'd0, mem_CS}, 32'd0);
    check("rst_mem_MAR", {24'd0, mem_MAR}, 32'd0);
    check("rst_mem_data_in", {8'd0, mem_data_in}, 32'd0);
    check("rst_acks", {30'd0, f_ack, d_ack}, 32'd0);
    check("rst_rdata", {8'd0, rdata}, 32'd0);
    check("rst_err_busy", {30'd0, err, busy}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed: fetch of preloaded cell, write/read, out-of-range
    run_txn(1'b1, 8'd20, 1'b0, 1'b0, 8'd0, 24'd0);
    run_txn(1'b0, 8'd0, 1'b1, 1'b1, 8'd31, 24'h00009);
    run_txn(1'b0, 8'd0, 1'b1, 1'b0, 8'd31, 24'd0);
    run_txn(1'b0, 8'd0, 1'b1, 1'b0, 8'd200, 24'd0);
    run_txn(1'b0, 8'd0, 1'b1, 1'b0, 8'd127, 24'd0);
    run_txn(1'b1, 8'd128, 1'b0, 1'b0, 8'd0, 24'd0);

    // Contention with both requests held across four grants
    held_seq(1'b1, 1'b1, 4);
    @(negedge clk);

    // Reset while the fetch is in CAPTURE
    @(negedge clk);
    f_req = 1'b1; f_addr = 8'd5;
    repeat (2) @(negedge clk);
    check("busy_in_capture", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    f_req = 1'b0;
    @(negedge clk);
    check("midrst_acks", {30'd0, f_ack, d_ack}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_mem_EN", {31'd0, mem_EN}, 32'd0);
    check("midrst_err", {31'd0, err}, 32'd0);
    reset = 1'b0;
    model_reset();
    run_txn(1'b1, 8'd5, 1'b0, 1'b0, 8'd0, 24'd0);

    // Back-to-back fetches with held request
    held_seq(1'b1, 1'b0, 5);

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      bit fe, de, we;
      logic [7:0] fa, da;
      logic [23:0] wd;
      fe = 1'($urandom);
      de = 1'($urandom);
      if (!fe && !de) de = 1'b1;
      fa = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(0, 127)) : 8'($urandom_range(128, 255));
      da = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(0, 127)) : 8'($urandom_range(128, 255));
      if ($urandom_range(0, 3) == 0) da = fa;
      we = 1'($urandom);
      wd = 24'($urandom);
      run_txn(fe, fa, de, we, da, wd);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (8) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Two-port arbiter and sequencer for the 128×24-bit synchronous memory.
- Shares the single memory port between the instruction-fetch requester (read-only) and the data requester (load/store/push/pop traffic).
- Drives the memory's `MAR`, `data_in`, `EN` and `CS` inputs, and captures `data_out` on the correct cycle.
- Returns a one-cycle acknowledge with read data, or an out-of-range error, to the granted requester.

## Interface
- `ADDR_W`, 8, address width (matches MAR).
- `DATA_W`, 24, word width.
- `DEPTH`, 128, number of valid cells; addresses ≥ `DEPTH` are errors.

- `clk`  in  1  clock; all state changes on posedge.
- `reset`  in  1  synchronous, active-high.
- `f_req`  in  1  fetch read request; level, held until `f_ack` is sampled.
- `f_addr`  in  ADDR_W  fetch address.
- `f_ack`  out  1  one-cycle fetch completion.
- `d_req`  in  1  data request; level, held until `d_ack` is sampled.
- `d_we`  in  1  1 = write, 0 = read.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  write data.
- `d_ack`  out  1  one-cycle data completion.
- `rdata`  out  DATA_W  read data; valid while either ack is high.
- `err`  out  1  out-of-range flag; valid while either ack is high.
- `busy`  out  1  high in every state except IDLE.
- `mem_MAR`  out  ADDR_W  memory address.
- `mem_data_in`  out  DATA_W  memory write data.
- `mem_EN`  out  1  memory enable.
- `mem_CS`  out  1  memory direction; 0 = read, 1 = write.
- `mem_data_out`  in  DATA_W  memory read data.

## Operation
- FSM states: IDLE → ISSUE → CAPTURE → DONE → IDLE. All outputs are registered.
- **IDLE:**
  - If no request is pending, stay in IDLE.
  - Otherwise pick a winner (priority below) and latch its address, write data and direction into `mem_MAR`, `mem_data_in` and `mem_CS`.
  - Set `mem_EN=1` only if address < `DEPTH`; otherwise keep `mem_EN=0` and set an internal error bit.
  - Go to ISSUE.
- **ISSUE:** the memory samples `EN` at the next edge. At that edge clear `mem_EN` and go to CAPTURE.
- **CAPTURE:**
  - At the next edge assert the winner's ack and go to DONE.
  - On a read with no error, load `rdata <= mem_data_out`.
  - On an error, load `rdata <= 0` and set `err <= 1`.
  - On a write, `rdata` holds its previous value and `err <= 0`.
- **DONE:** ack is high for exactly this cycle. At the next edge clear ack and `err`, and go to IDLE.
  - No sampling occurs in DONE, so the requester has time to drop `req`.
- Fetch requests are always reads: `mem_CS=0`, and `mem_data_in` is don't-care (driven 0).
- Fixed priority: `d_req` beats `f_req` when both are pending in IDLE.
- Request signals sampled outside IDLE are ignored; a pending request waits.
- Address check is an unsigned compare of the full `ADDR_W` bits against `DEPTH`.
- A requester that drops `req` before its ack still receives the ack; the access is not cancelled.

## Timing
- Reset values:
  - State IDLE.
  - `mem_EN=0`, `mem_CS=0`, `mem_MAR=0`, `mem_data_in=0`.
  - `f_ack=0`, `d_ack=0`, `rdata=0`, `err=0`, `busy=0`.
  - Round-robin pointer favours data.
- Request seen at edge N:
  - `mem_EN` high during (N, N+1].
  - Memory acts at edge N+1; its `data_out` settles after N+1.
  - Capture at N+2, so ack is high during (N+2, N+3].
  - IDLE is re-entered at N+3; the earliest next grant is edge N+4.
- Maximum throughput: one access per 4 cycles.
- Reset asserted mid-transaction:
  - Return to IDLE at that edge with all outputs at their reset values; no ack is issued.
  - If the reset edge coincides with the ISSUE→CAPTURE edge, the memory has already performed the access. A write therefore lands without an ack; this is accepted behaviour.
- `busy` is high from the edge after the grant through the DONE cycle.

## Configuration
- `MEM_ARB_RR_EN`:
  - Defined: round-robin arbitration. A 1-bit last-grant pointer updates on each grant. When both requesters are pending, the one not granted last wins. The first contention after reset goes to data.
  - Undefined: fixed data-over-fetch priority, and no pointer register exists.

## Test plan
- Fetch read: preload cell 20=0x3128A, `f_req=1`, `f_addr=20`. Expected: `mem_EN` high for exactly one cycle with `mem_MAR=20`, `mem_CS=0`; `f_ack` high 3 cycles after the grant edge with `rdata=0x3128A`, `err=0`.
- Data write then read: `d_we=1`, `d_addr=31`, `d_wdata=0x00009`. Expected: `mem_CS=1`, `d_ack` returned. A following read of 31 returns `rdata=0x00009`.
- Contention: `f_req` and `d_req` asserted in the same cycle and held after each ack.
  - Without `MEM_ARB_RR_EN`: data is granted every time.
  - With `MEM_ARB_RR_EN`: grants alternate D, F, D, F, each 4 cycles apart.
- Out of range: `d_addr=200`, read. Expected: `mem_EN` stays 0, `d_ack` arrives with `err=1`, `rdata=0`, and the same latency as a normal access.
- Reset mid-op: assert `reset` in the CAPTURE state. Expected: no ack, `busy=0`, `mem_EN=0` on the next cycle; a subsequent fetch completes normally.
- Back-to-back fetches: hold `f_req`, toggling `f_addr` after each ack. Expected: grants exactly 4 cycles apart and no duplicate ack.
